// File: rtl/fp_fmul_fadd_4_4.sv
// fp_fmul_fadd_4_4
//   FloPoCo-format (2-bit exception, sign, 4-bit exponent bias 7, 4-bit fraction)
//   multiplier and adder sharing one clock and reset, each gated by its own
//   clock enable. Rounding is round-to-nearest-even; no subnormals.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low clear of every pipeline register
//   mul_ce         multiplier enable; mul_r updates 1 enabled edge after operands
//   mul_x, mul_y   multiplier operands
//   mul_r          product
//   add_ce         adder enable; add_r updates 2 enabled edges after operands
//   add_x, add_y   adder operands
//   add_r          sum
module fp_fmul_fadd_4_4 #(
  parameter int WE = 4,
  parameter int WF = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_ce,
  input  logic [WE+WF+2:0] mul_x,
  input  logic [WE+WF+2:0] mul_y,
  output logic [WE+WF+2:0] mul_r,
  input  logic             add_ce,
  input  logic [WE+WF+2:0] add_x,
  input  logic [WE+WF+2:0] add_y,
  output logic [WE+WF+2:0] add_r
);

  localparam logic [1:0]  EXC_ZERO = 2'b00;
  localparam logic [1:0]  EXC_NORM = 2'b01;
  localparam logic [1:0]  EXC_INF  = 2'b10;
  localparam logic [1:0]  EXC_NAN  = 2'b11;
  localparam logic [10:0] NAN_WORD = 11'b11_0_0000_0000;

  // ---------------------------------------------------------------- multiplier
  logic [1:0]  mxe, mye;
  logic        mxs, mys, msgn;
  logic [3:0]  mxexp, myexp, mxf, myf;
  logic [9:0]  mprod;
  logic        mnorm, mrnd, mstk, minc;
  logic [3:0]  mfrac;
  logic [4:0]  mfrac_r;
  logic [5:0]  mexp;     // two's complement; bit 5 set means underflow
  logic [10:0] mul_nxt;

  assign {mxe, mxs, mxexp, mxf} = mul_x;
  assign {mye, mys, myexp, myf} = mul_y;
  assign msgn = mxs ^ mys;

  always_comb begin
    mprod = {5'b0, 1'b1, mxf} * {5'b0, 1'b1, myf};
    mnorm = mprod[9];
    if (mnorm) begin
      mfrac = mprod[8:5];
      mrnd  = mprod[4];
      mstk  = |mprod[3:0];
    end else begin
      mfrac = mprod[7:4];
      mrnd  = mprod[3];
      mstk  = |mprod[2:0];
    end
    minc    = mrnd & (mstk | mfrac[0]);
    mfrac_r = {1'b0, mfrac} + {4'b0, minc};
    // fraction carry-out leaves mfrac_r[3:0] == 0, so only the exponent moves
    mexp    = {2'b0, mxexp} + {2'b0, myexp} + {5'b0, mnorm} + {5'b0, mfrac_r[4]} - 6'd7;

    if (mxe == EXC_NAN || mye == EXC_NAN ||
        (mxe == EXC_ZERO && mye == EXC_INF) || (mxe == EXC_INF && mye == EXC_ZERO))
      mul_nxt = NAN_WORD;
    else if (mxe == EXC_INF || mye == EXC_INF)
      mul_nxt = {EXC_INF, msgn, 8'b0};
    else if (mxe == EXC_ZERO || mye == EXC_ZERO)
      mul_nxt = {EXC_ZERO, msgn, 8'b0};
    else if (mexp[5])
      mul_nxt = {EXC_ZERO, msgn, 8'b0};
    else if (mexp[4])
      mul_nxt = {EXC_INF, msgn, 8'b0};
    else
      mul_nxt = {EXC_NORM, msgn, mexp[3:0], mfrac_r[3:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      mul_r <= '0;
    else if (mul_ce) mul_r <= mul_nxt;
  end

  // ------------------------------------------------------------ adder stage 1
  // Either the result is already fully known (special) or we carry the
  // aligned sum with 3 guard/round/sticky bits below the significand.
  typedef struct packed {
    logic        spec;
    logic [10:0] word;
    logic        sgn;
    logic [3:0]  exp;
    logic [8:0]  sum;   // [8] carry, [7:3] significand, [2:0] g/r/s
  } add_s1_t;

  add_s1_t     s1, s1_nxt;
  logic [1:0]  axe, aye;
  logic        axs, ays, x_big, big_s, sml_s;
  logic [3:0]  axexp, ayexp, axf, ayf, big_e, sml_e, big_f, sml_f, dsh;
  logic [15:0] sml_sh;
  logic [7:0]  a_al, b_al;

  assign {axe, axs, axexp, axf} = add_x;
  assign {aye, ays, ayexp, ayf} = add_y;

  always_comb begin
    x_big = {axexp, axf} >= {ayexp, ayf};
    big_s = x_big ? axs   : ays;
    big_e = x_big ? axexp : ayexp;
    big_f = x_big ? axf   : ayf;
    sml_s = x_big ? ays   : axs;
    sml_e = x_big ? ayexp : axexp;
    sml_f = x_big ? ayf   : axf;
    dsh   = big_e - sml_e;
    // wide shifter keeps every shifted-out bit so sticky is exact for any distance
    sml_sh = {1'b1, sml_f, 11'b0} >> dsh;
    b_al   = {sml_sh[15:9], sml_sh[8] | (|sml_sh[7:0])};
    a_al   = {1'b1, big_f, 3'b0};

    s1_nxt      = '0;
    s1_nxt.sgn  = big_s;
    s1_nxt.exp  = big_e;
    s1_nxt.sum  = (big_s ^ sml_s) ? ({1'b0, a_al} - {1'b0, b_al})
                                  : ({1'b0, a_al} + {1'b0, b_al});

    if (axe == EXC_NAN || aye == EXC_NAN ||
        (axe == EXC_INF && aye == EXC_INF && axs != ays)) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = NAN_WORD;
    end else if (axe == EXC_INF) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = {EXC_INF, axs, 8'b0};
    end else if (aye == EXC_INF) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = {EXC_INF, ays, 8'b0};
    end else if (axe == EXC_ZERO && aye == EXC_ZERO) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = {EXC_ZERO, axs & ays, 8'b0};
    end else if (axe == EXC_ZERO) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = add_y;
    end else if (aye == EXC_ZERO) begin
      s1_nxt.spec = 1'b1;
      s1_nxt.word = add_x;
    end
  end

  // ------------------------------------------------------------ adder stage 2
  logic [2:0]  lz;
  logic [6:0]  nsh;
  logic [3:0]  afrac;
  logic        arnd, astk, ainc;
  logic [4:0]  afrac_r;
  logic [5:0]  aexp_adj, aexp;   // two's complement
  logic [10:0] add_nxt;

  always_comb begin
    // A non-zero sum always has its leading one within sum[7:2]: cancellation
    // deep enough to reach the low bits only happens at shift 0/1, where the
    // bottom bits of the difference are zero.
    lz = 3'd6;
    for (int i = 0; i < 6; i++)
      if (s1.sum[2+i]) lz = 3'(5 - i);
    nsh = s1.sum[6:0] << lz;

    if (s1.sum[8]) begin
      afrac    = s1.sum[7:4];
      arnd     = s1.sum[3];
      astk     = |s1.sum[2:0];
      aexp_adj = {2'b0, s1.exp} + 6'd1;
    end else begin
      afrac    = nsh[6:3];
      arnd     = nsh[2];
      astk     = |nsh[1:0];
      aexp_adj = {2'b0, s1.exp} - {3'b0, lz};
    end
    ainc    = arnd & (astk | afrac[0]);
    afrac_r = {1'b0, afrac} + {4'b0, ainc};
    aexp    = aexp_adj + {5'b0, afrac_r[4]};

    if (s1.spec)
      add_nxt = s1.word;
    else if (s1.sum == 9'd0)
      add_nxt = '0;                           // exact cancellation is +0
    else if (aexp[5])
      add_nxt = {EXC_ZERO, s1.sgn, 8'b0};
    else if (aexp[4])
      add_nxt = {EXC_INF, s1.sgn, 8'b0};
    else
      add_nxt = {EXC_NORM, s1.sgn, aexp[3:0], afrac_r[3:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1    <= '0;
      add_r <= '0;
    end else if (add_ce) begin
      s1    <= s1_nxt;
      add_r <= add_nxt;
    end
  end

endmodule

// File: tb/tb_fp_fmul_fadd_4_4.sv
module tb_fp_fmul_fadd_4_4;

  logic        clk, reset;
  logic        mul_ce, add_ce;
  logic [10:0] mul_x, mul_y, mul_r, add_x, add_y, add_r;

  int checks = 0;
  int errors = 0;

  localparam logic [10:0] P0    = 11'b00_0_0000_0000;
  localparam logic [10:0] N0    = 11'b00_1_0000_0000;
  localparam logic [10:0] P1    = 11'b01_0_0111_0000;
  localparam logic [10:0] P1_0625 = 11'b01_0_0111_0001;
  localparam logic [10:0] P1_125  = 11'b01_0_0111_0010;
  localparam logic [10:0] P1_5  = 11'b01_0_0111_1000;
  localparam logic [10:0] P2    = 11'b01_0_1000_0000;
  localparam logic [10:0] N2    = 11'b01_1_1000_0000;
  localparam logic [10:0] N1    = 11'b01_1_0111_0000;
  localparam logic [10:0] P3    = 11'b01_0_1000_1000;
  localparam logic [10:0] N3    = 11'b01_1_1000_1000;
  localparam logic [10:0] P4    = 11'b01_0_1001_0000;
  localparam logic [10:0] P5    = 11'b01_0_1001_0100;
  localparam logic [10:0] P6    = 11'b01_0_1001_1000;
  localparam logic [10:0] P7    = 11'b01_0_1001_1100;
  localparam logic [10:0] P8    = 11'b01_0_1010_0000;
  localparam logic [10:0] P12   = 11'b01_0_1010_1000;
  localparam logic [10:0] P14   = 11'b01_0_1010_1100;
  localparam logic [10:0] P16   = 11'b01_0_1011_0000;
  localparam logic [10:0] P30   = 11'b01_0_1011_1110;
  localparam logic [10:0] P32   = 11'b01_0_1100_0000;
  localparam logic [10:0] P44   = 11'b01_0_1100_0110;
  localparam logic [10:0] P56   = 11'b01_0_1100_1100;
  localparam logic [10:0] P100  = 11'b01_0_1101_1001;
  localparam logic [10:0] PMAX  = 11'b01_0_1111_1111;
  localparam logic [10:0] PTINY = 11'b01_0_0001_0000;
  localparam logic [10:0] NTINY = 11'b01_1_0001_0000;
  localparam logic [10:0] P2M5  = 11'b01_0_0010_0000;
  localparam logic [10:0] PINF  = 11'b10_0_0000_0000;
  localparam logic [10:0] NINF  = 11'b10_1_0000_0000;
  localparam logic [10:0] QNAN  = 11'b11_0_0000_0000;

  fp_fmul_fadd_4_4 #(.WE(4), .WF(4)) dut (
    .clk(clk), .reset(reset),
    .mul_ce(mul_ce), .mul_x(mul_x), .mul_y(mul_y), .mul_r(mul_r),
    .add_ce(add_ce), .add_x(add_x), .add_y(add_y), .add_r(add_r)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // one rising edge, then settle so outputs are sampled away from the edge
  task automatic edge_();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input logic [10:0] x, input logic [10:0] y);
    mul_x = x; mul_y = y; mul_ce = 1'b1;
    edge_();
    mul_ce = 1'b0;
  endtask

  task automatic do_add(input logic [10:0] x, input logic [10:0] y);
    add_x = x; add_y = y; add_ce = 1'b1;
    edge_();
    edge_();
    add_ce = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mul_ce = 1'b0; add_ce = 1'b0;
    mul_x = P3; mul_y = P4; add_x = P3; add_y = P4;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mul_r !== P0) begin errors++; $display("FAIL reset_mul_r: got %b expected %b", mul_r, P0); end
    checks++;
    if (add_r !== P0) begin errors++; $display("FAIL reset_add_r: got %b expected %b", add_r, P0); end
    edge_();
    reset = 1'b1;
  endtask

  task automatic test_mul();
    logic [10:0] xs [8] = '{P1, P3, N1, P1_0625, P1_0625, P5, P7, P1};
    logic [10:0] ys [8] = '{P2, P4, P2, P1_0625, P1_5,    P6, P8, PINF};
    logic [10:0] es [8] = '{P2, P12, N2, P1_125, 11'b01_0_0111_1010, P30, P56, PINF};
    for (int i = 0; i < 8; i++) begin
      do_mul(xs[i], ys[i]);
      checks++;
      if (mul_r !== es[i]) begin
        errors++; $display("FAIL mul_vec%0d: got %b expected %b", i, mul_r, es[i]);
      end
    end
    // disabled edges hold the product even with new operands
    mul_x = P7; mul_y = P7; mul_ce = 1'b0;
    edge_(); edge_();
    checks++;
    if (mul_r !== PINF) begin errors++; $display("FAIL mul_hold: got %b expected %b", mul_r, PINF); end
  endtask

  task automatic test_accumulate();
    logic [10:0] prods [3] = '{P12, P30, P56};
    logic [10:0] sums  [3] = '{P14, P44, P100};
    logic [10:0] ax    [3] = '{P3, P5, P7};
    logic [10:0] ay    [3] = '{P4, P6, P8};
    logic [10:0] acc;
    do_add(P0, P2);
    checks++;
    if (add_r !== P2) begin errors++; $display("FAIL acc_init: got %b expected %b", add_r, P2); end
    for (int i = 0; i < 3; i++) begin
      do_mul(ax[i], ay[i]);
      checks++;
      if (mul_r !== prods[i]) begin
        errors++; $display("FAIL acc_prod%0d: got %b expected %b", i, mul_r, prods[i]);
      end
      acc = add_r;
      do_add(acc, mul_r);
      checks++;
      if (add_r !== sums[i]) begin
        errors++; $display("FAIL acc_sum%0d: got %b expected %b", i, add_r, sums[i]);
      end
    end
  endtask

  task automatic test_exceptions();
    logic [10:0] mx [4] = '{P16, P0,   PTINY, NTINY};
    logic [10:0] my [4] = '{P32, PINF, PTINY, PTINY};
    logic [10:0] me [4] = '{PINF, QNAN, P0,   N0};
    logic [10:0] ax [7] = '{PINF, P3, N0, QNAN, PINF, PMAX, P0};
    logic [10:0] ay [7] = '{NINF, N3, N0, P1,   P1,   PMAX, N3};
    logic [10:0] ae [7] = '{QNAN, P0, N0, QNAN, PINF, PINF, N3};
    for (int i = 0; i < 4; i++) begin
      do_mul(mx[i], my[i]);
      checks++;
      if (mul_r !== me[i]) begin
        errors++; $display("FAIL mul_exc%0d: got %b expected %b", i, mul_r, me[i]);
      end
    end
    for (int i = 0; i < 7; i++) begin
      do_add(ax[i], ay[i]);
      checks++;
      if (add_r !== ae[i]) begin
        errors++; $display("FAIL add_exc%0d: got %b expected %b", i, add_r, ae[i]);
      end
    end
  endtask

  task automatic test_rounding();
    do_add(P1, P2M5);
    checks++;
    if (add_r !== P1) begin errors++; $display("FAIL tie_even_down: got %b expected %b", add_r, P1); end
    do_add(P1_0625, P2M5);
    checks++;
    if (add_r !== P1_125) begin errors++; $display("FAIL tie_even_up: got %b expected %b", add_r, P1_125); end
    do_add(P2, P1);
    checks++;
    if (add_r !== P3) begin errors++; $display("FAIL add_align1: got %b expected %b", add_r, P3); end
  endtask

  task automatic test_enable_gating();
    do_add(P1, P1);
    checks++;
    if (add_r !== P2) begin errors++; $display("FAIL gate_pre: got %b expected %b", add_r, P2); end
    // first enabled edge: stage 1 takes 3+4, add_r shows the repeated 1+1
    add_x = P3; add_y = P4; add_ce = 1'b1;
    edge_();
    add_ce = 1'b0;
    add_x = QNAN; add_y = QNAN;
    for (int i = 0; i < 5; i++) begin
      edge_();
      checks++;
      if (add_r !== P2) begin
        errors++; $display("FAIL gate_idle%0d: got %b expected %b", i, add_r, P2);
      end
    end
    add_ce = 1'b1;
    edge_();
    add_ce = 1'b0;
    checks++;
    if (add_r !== P7) begin errors++; $display("FAIL gate_result: got %b expected %b", add_r, P7); end
  endtask

  task automatic test_back_to_back();
    logic [10:0] xs [4] = '{P1, P3, P0, P0};
    logic [10:0] ys [4] = '{P2, P4, N3, P0};
    logic [10:0] es [4] = '{P7, P3, P7, N3};
    add_ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      add_x = xs[i]; add_y = ys[i];
      edge_();
      // result of issue i lands one edge after issue i+1
      if (i > 0) begin
        checks++;
        if (add_r !== es[i]) begin
          errors++; $display("FAIL b2b_%0d: got %b expected %b", i, add_r, es[i]);
        end
      end
    end
    add_ce = 1'b0;
  endtask

  task automatic test_reset_midpipe();
    do_add(P1, P2);
    checks++;
    if (add_r !== P3) begin errors++; $display("FAIL rst_pre: got %b expected %b", add_r, P3); end
    add_x = P4; add_y = P4; add_ce = 1'b1;
    mul_x = P3; mul_y = P4; mul_ce = 1'b1;
    edge_();
    add_ce = 1'b0; mul_ce = 1'b0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if (mul_r !== P0) begin errors++; $display("FAIL rst_mid_mul: got %b expected %b", mul_r, P0); end
    checks++;
    if (add_r !== P0) begin errors++; $display("FAIL rst_mid_add: got %b expected %b", add_r, P0); end
    edge_();
    reset = 1'b1;
    // first enabled edge must flush the cleared stage 1, not the discarded 4+4
    add_x = P1; add_y = P1; add_ce = 1'b1;
    edge_();
    checks++;
    if (add_r !== P0) begin errors++; $display("FAIL rst_stale: got %b expected %b", add_r, P0); end
    edge_();
    add_ce = 1'b0;
    checks++;
    if (add_r !== P2) begin errors++; $display("FAIL rst_after_add: got %b expected %b", add_r, P2); end
    do_mul(P2, P2);
    checks++;
    if (mul_r !== P4) begin errors++; $display("FAIL rst_after_mul: got %b expected %b", mul_r, P4); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_accumulate();
    test_exceptions();
    test_rounding();
    test_enable_gating();
    test_back_to_back();
    test_reset_midpipe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
